// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drain stage behind a 16-bit FIFO.
// Pops 16-bit words and packs each pair into one 32-bit word: the older word goes to [15:0].
// Packed words are presented on a valid/ready port.
// A lone low half is padded with PAD_WORD and flagged with out_half when either:
//   - flush is high, or
//   - the FIFO has stayed empty for FLUSH_DLY cycles.
// Optional feature macro PACKER_PARITY_EN adds the out_par port: even parity of out_data.
module fifo_rd_packer #(
  parameter logic [15:0] PAD_WORD  = 16'h0000,
  parameter int unsigned FLUSH_DLY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fifo_rd,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        flush,
  output logic [31:0] out_data,
  output logic        out_half,
  output logic        out_valid,
  input  logic        out_ready
`ifdef PACKER_PARITY_EN
  ,
  output logic        out_par
`endif
);

  localparam int unsigned     CNT_W     = (FLUSH_DLY < 2) ? 1 : $clog2(FLUSH_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_DLY);
  localparam logic             FLUSH_EN  = (FLUSH_DLY != 32'd0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LO   = 3'd1,
    S_CAP_LO  = 3'd2,
    S_WAIT_HI = 3'd3,
    S_RD_HI   = 3'd4,
    S_CAP_HI  = 3'd5,
    S_OUT     = 3'd6
  } state_e;

  logic [1:0]       rst_sync_q;
  logic             rst_sync_n;
  state_e           state_q, state_d;
  logic [15:0]      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_half_q, out_half_d;
  logic             out_valid_q, out_valid_d;

  // Reset assertion propagates immediately; release is aligned to clk through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  // Next-state, read-strobe and output-word computation for the pack FSM.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    fifo_rd_d   = 1'b0;
    out_data_d  = out_data_q;
    out_half_d  = out_half_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d   = S_RD_LO;
          fifo_rd_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_LO: begin
        state_d = S_CAP_LO;
      end
      S_CAP_LO: begin
        lo_d    = fifo_dout;
        cnt_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A real high word always wins over padding.
        if (!fifo_empty) begin
          state_d   = S_RD_HI;
          fifo_rd_d = 1'b1;
        end else if (flush || (FLUSH_EN && (cnt_q == FLUSH_CNT))) begin
          out_data_d  = {PAD_WORD, lo_q};
          out_half_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RD_HI: begin
        state_d = S_CAP_HI;
      end
      S_CAP_HI: begin
        out_data_d  = {fifo_dout, lo_q};
        out_half_d  = 1'b0;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        // No read is issued until the held word has been accepted.
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            state_d   = S_RD_LO;
            fifo_rd_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and all outputs are registered.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q     <= S_IDLE;
      lo_q        <= 16'h0000;
      cnt_q       <= '0;
      fifo_rd_q   <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_half_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      fifo_rd_q   <= fifo_rd_d;
      out_data_q  <= out_data_d;
      out_half_q  <= out_half_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign out_data  = out_data_q;
  assign out_half  = out_half_q;
  assign out_valid = out_valid_q;

`ifdef PACKER_PARITY_EN
  logic out_par_q, out_par_d;

  function automatic logic even_par32(input logic [31:0] v);
    return ^v;
  endfunction

  assign out_par_d = even_par32(out_data_d);

  // Parity is registered alongside the data word so the two always match.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer.
// Uses a behavioural FIFO model, a scoreboard of expected packed words and a vector table.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_rd;
  logic [15:0] fifo_dout  = 16'h0000;
  logic        fifo_empty = 1'b1;
  logic        flush;
  logic [31:0] out_data;
  logic        out_half;
  logic        out_valid;
  logic        out_ready;
`ifdef PACKER_PARITY_EN
  logic        out_par;
`endif

  always #5 clk = ~clk;

  fifo_rd_packer #(.PAD_WORD(16'h0000), .FLUSH_DLY(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .flush      (flush),
    .out_data   (out_data),
    .out_half   (out_half),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef PACKER_PARITY_EN
    ,
    .out_par    (out_par)
`endif
  );

  typedef struct packed {
    logic [31:0] d;
    logic        h;
  } exp_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    bit          pair;
    bit          use_flush;
    logic [31:0] exp_d;
    logic        exp_h;
    int          exp_lat;
    int          exp_rd;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_count = 0;
  logic [15:0] fifo_q[$];
  exp_t        sb_q[$];
  logic [15:0] pend_lo;
  bit          pend_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // FIFO model: pops on the edge that samples fifo_rd; empty flag is registered.
  always @(posedge clk) begin
    if (fifo_rd) begin
      check("rd_when_empty", (fifo_q.size() != 0), 1'b1);
      if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Output monitor: scoreboard compare, hold-stability and no-read-while-valid checks.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_half = 1'b0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (fifo_rd) rd_count++;
    if (rst_n) begin
      if (out_valid) check("no_rd_while_valid", fifo_rd, 1'b0);
      if (prev_hold && out_valid) begin
        check("hold_data", out_data, prev_data);
        check("hold_half", out_half, prev_half);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word", out_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_data", out_data, mon_e.d);
          check("out_half", out_half, mon_e.h);
`ifdef PACKER_PARITY_EN
          check("out_par", out_par, ^mon_e.d);
`endif
        end
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_half = out_half;
  end

  task automatic push_word(input logic [15:0] w);
    exp_t e;
    fifo_q.push_back(w);
    if (pend_v) begin
      e.d = {w, pend_lo};
      e.h = 1'b0;
      sb_q.push_back(e);
      pend_v = 1'b0;
    end else begin
      pend_lo = w;
      pend_v  = 1'b1;
    end
  endtask

  task automatic wait_rd(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fifo_rd) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while ((sb_q.size() != 0 || fifo_q.size() != 0 || out_valid) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drain"}, (i < budget), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[6];
  exp_t te;
  int   base;
  int   lat;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0, 0, 2};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 0, 2};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b0, 1'b0, 32'h0000_00FF, 1'b1, 7, 1};
    vecs[3] = '{16'h8001, 16'h0000, 1'b0, 1'b1, 32'h0000_8001, 1'b1, 3, 1};
    vecs[4] = '{16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 32'hBEEF_DEAD, 1'b0, 0, 2};
    vecs[5] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 0, 2};

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    pend_v    = 1'b0;
    pend_lo   = 16'h0;

    // Reset with a non-empty FIFO: no read, no output.
    repeat (2) @(posedge clk);
    #1 push_word(16'h1234);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_fifo_rd", fifo_rd, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
    end
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_half", out_half, 1'b0);
`ifdef PACKER_PARITY_EN
    check("rst_out_par", out_par, 1'b0);
`endif
    base = rd_count;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic pair: 1234 then ABCD.
    @(posedge clk);
    #1 push_word(16'hABCD);
    wait_drain("pair", 200);
    check("pair_rd_count", rd_count - base, 2);
    check("pair_fifo_empty", fifo_empty, 1'b1);

    // Table-driven vectors: full pairs, auto flush and explicit flush.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      base = rd_count;
      te.d = vecs[k].exp_d;
      te.h = vecs[k].exp_h;
      sb_q.push_back(te);
      fifo_q.push_back(vecs[k].lo);
      if (vecs[k].pair) begin
        fifo_q.push_back(vecs[k].hi);
      end else begin
        flush = vecs[k].use_flush;
        wait_rd("vec_rd");
        lat = 0;
        while (!out_valid && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        check("vec_flush_lat", lat, vecs[k].exp_lat);
        @(posedge clk);
        #1 flush = 1'b0;
      end
      wait_drain("vec", 200);
      check("vec_rd_count", rd_count - base, vecs[k].exp_rd);
    end

    // Backpressure: two pairs queued, consumer stalls for 10 cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    push_word(16'h4444);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_valid_seen", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, 32'h2222_1111);
      check("bp_fifo_rd", fifo_rd, 1'b0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("bp", 200);

    // Flush rises in the same cycle the FIFO turns non-empty: the real hi word wins.
    @(posedge clk);
    #1 push_word(16'hC0DE);
    wait_rd("race_rd_lo");
    @(posedge clk);
    @(posedge clk);
    #1 push_word(16'hF00D);
    @(posedge clk);
    #1 flush = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("race_half", out_half, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0;
    wait_drain("race", 200);

    // Reset while capturing the hi half: the pair is discarded, the next pair starts fresh.
    @(posedge clk);
    #1;
    push_word(16'h7777);
    push_word(16'h8888);
    wait_rd("mid_rd_lo");
    wait_rd("mid_rd_hi");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_fifo_rd", fifo_rd, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 32'h0);
    check("mid_rst_half", out_half, 1'b0);
    sb_q.delete();
    pend_v = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_idle_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    push_word(16'h9999);
    push_word(16'hAAAA);
    wait_drain("mid", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
